reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Write-side front end of the integer register file.
- Merges single-cycle pipeline writebacks with results from long-latency units (mul/div, misaligned-load sequencer) onto the file's single write port.
- Buffers long-latency results in a small FIFO; drains them in the pipeline's idle writeback slots.
- Holds a pending-destination scoreboard that decode uses to stall RAW/WAW hazards on outstanding long-latency destinations.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive blocked cycles with a non-empty FIFO before a writeback bubble is requested.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_wr_en  in  1  pipeline writeback valid; always accepted, highest priority.
- pipe_wr_addr  in  5  pipeline destination register.
- pipe_wr_data  in  32  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept; equals !full.
- lu_addr  in  5  long-latency destination register.
- lu_data  in  32  long-latency result data.
- issue_en  in  1  decode issued a long-latency op this cycle.
- issue_addr  in  5  its destination register.
- chk_addr1  in  5  decode source/destination query 1.
- chk_addr2  in  5  decode source/destination query 2.
- hazard_stall  out  1  a queried register has its pending bit set.
- wb_bubble_req  out  1  request one pipeline writeback bubble.
- rf_regwrite  out  1  register file write enable.
- rf_write_reg  out  5  register file write address.
- rf_write_data  out  32  register file write data.
- pending  out  32  scoreboard bitmap; bit 0 is always 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; pointers, count, starvation counter and pending all cleared.
  - lu_ready=1; wb_bubble_req=0.
  - rf_regwrite=0, rf_write_reg=0, rf_write_data=0.
- Reset mid-operation: queued results and pending bits are discarded with no commit.
- FIFO enqueue: on a clock edge with lu_valid && lu_ready.
  - lu_addr=0: the handshake completes but nothing is stored.
- Write port selection is combinational, in this priority order:
  - pipe_wr_en=1: pipeline write drives rf_*; FIFO head held.
  - else FIFO non-empty: head drives rf_*, with rf_regwrite=1; head popped at the edge (commit).
  - else rf_regwrite=0, rf_write_reg=0, rf_write_data=0.
- Minimum latency: a result enqueued at edge N commits in cycle N+1 at the earliest.
- Full FIFO: lu_ready=0.
  - A pop in the same cycle does not raise lu_ready; there is no full-bypass.
  - The source holds lu_valid and lu_addr/lu_data stable until the handshake.
- Scoreboard:
  - Set: issue_en && issue_addr!=0 sets pending[issue_addr] at the edge.
  - Clear: a FIFO commit clears pending[head addr] at the edge.
  - Set and clear on the same register in the same cycle: set wins (new op outstanding).
- hazard_stall = (chk_addr1!=0 && pending[chk_addr1]) || (chk_addr2!=0 && pending[chk_addr2]).
  - Combinational on the registered bitmap.
- Starvation counter:
  - Increments each cycle FIFO is non-empty and pipe_wr_en=1.
  - Resets to 0 on any FIFO commit or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - wb_bubble_req=1 while counter==STARVE_MAX; it is registered, so it asserts the cycle after the count is reached.
- The pipeline is never backpressured by this block, except through wb_bubble_req and hazard_stall.
- Occupancy wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty come from a log2(DEPTH)+1-bit count.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_wr_en=0 and lu_valid=1 with lu_addr!=0, the result drives rf_* directly in the same cycle and is not enqueued. This counts as a commit (pending cleared; 0-cycle latency). The lu_addr=0 rule is unchanged.
- Not defined: every long-latency result passes through the FIFO; minimum latency is 1 cycle.

Test Plan:
- Reset release, idle: rf_regwrite=0, lu_ready=1, pending=0, wb_bubble_req=0.
- Pipeline only: pipe_wr_en=1, addr=5, data=0x1234 -> same cycle rf_regwrite=1, rf_write_reg=5, rf_write_data=0x1234.
- Issue then complete:
  - issue_en with addr=7 -> pending[7]=1.
  - chk_addr1=7 -> hazard_stall=1.
  - lu result addr=7, data=0xCAFE with pipe idle -> committed next cycle (same cycle with WB_BYPASS_EN); pending[7]=0; hazard_stall=0.
- Fill under contention:
  - pipe_wr_en held 1 while 4 lu results are pushed -> lu_ready=0 after the 4th push.
  - After 8 blocked cycles, wb_bubble_req=1.
  - Drop pipe_wr_en -> FIFO commits in push order, one per cycle; bubble request clears.
- x0 handling: lu_addr=0 is accepted and never written; issue_addr=0 leaves pending=0; chk_addr=0 never stalls.
- Simultaneous set/clear: issue addr=3 in the same cycle as the commit of addr 3 -> pending[3] stays 1.
- Async reset with 3 queued entries -> FIFO empty and pending=0 immediately, with no rf write.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Write-side front end of the integer register file.
// Merges single-cycle pipeline writebacks with buffered long-latency results onto the single
// write port, and tracks outstanding long-latency destinations for decode hazard stalls.
// Optional build macro: WB_BYPASS_EN (lets a long-latency result write straight through when
// the FIFO is empty and the pipeline slot is idle).
module reg_wb_arbiter #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pipe_wr_en,
   input  logic [4:0]  pipe_wr_addr,
   input  logic [31:0] pipe_wr_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   input  logic        issue_en,
   input  logic [4:0]  issue_addr,
   input  logic [4:0]  chk_addr1,
   input  logic [4:0]  chk_addr2,
   output logic        hazard_stall,
   output logic        wb_bubble_req,
   output logic        rf_regwrite,
   output logic [4:0]  rf_write_reg,
   output logic [31:0] rf_write_data,
   output logic [31:0] pending
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          bubble_q;
   logic [31:0]   pending_q, pending_d;

   logic          full, empty, bypass, push, pop;
   logic          commit;
   logic [4:0]    commit_addr;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   // Ready depends only on registered occupancy: a same-cycle pop never frees a slot early.
   assign lu_ready = !full;

`ifdef WB_BYPASS_EN
   assign bypass = empty && !pipe_wr_en && lu_valid && (lu_addr != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // Writes to x0 complete the handshake but are dropped; bypassed results skip the FIFO.
   assign push = lu_valid && lu_ready && (lu_addr != 5'd0) && !bypass;
   assign pop  = !pipe_wr_en && !empty;

   // Write-port priority: pipeline, then FIFO head, then (optional) direct bypass.
   always_comb begin
      rf_regwrite   = 1'b0;
      rf_write_reg  = 5'd0;
      rf_write_data = 32'd0;
      commit        = 1'b0;
      commit_addr   = 5'd0;
      if (pipe_wr_en) begin
         rf_regwrite   = 1'b1;
         rf_write_reg  = pipe_wr_addr;
         rf_write_data = pipe_wr_data;
      end else if (!empty) begin
         rf_regwrite   = 1'b1;
         rf_write_reg  = addr_q[rd_ptr_q];
         rf_write_data = data_q[rd_ptr_q];
         commit        = 1'b1;
         commit_addr   = addr_q[rd_ptr_q];
      end else if (bypass) begin
         rf_regwrite   = 1'b1;
         rf_write_reg  = lu_addr;
         rf_write_data = lu_data;
         commit        = 1'b1;
         commit_addr   = lu_addr;
      end
   end

   // Scoreboard next state: clear on commit first so a same-cycle issue wins.
   always_comb begin
      pending_d = pending_q;
      if (commit) begin
         pending_d[commit_addr] = 1'b0;
      end
      if (issue_en && (issue_addr != 5'd0)) begin
         pending_d[issue_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Occupancy and starvation counter next state.
   always_comb begin
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      starve_d = starve_q;
      if (empty || commit) begin
         starve_d = '0;
      end else if (pipe_wr_en && (starve_q != CW'(STARVE_MAX))) begin
         starve_d = starve_q + CW'(1);
      end
   end

   // FIFO storage and pointers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 5'd0;
            data_q[i] <= 32'd0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            addr_q[wr_ptr_q] <= lu_addr;
            data_q[wr_ptr_q] <= lu_data;
            wr_ptr_q         <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   // Scoreboard, starvation counter and registered bubble request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= 32'd0;
         starve_q  <= '0;
         bubble_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
         bubble_q  <= (starve_q == CW'(STARVE_MAX));
      end
   end

   assign pending       = pending_q;
   assign wb_bubble_req = bubble_q;
   assign hazard_stall  = ((chk_addr1 != 5'd0) && pending_q[chk_addr1]) ||
                          ((chk_addr2 != 5'd0) && pending_q[chk_addr2]);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: stimulus pushes expected register-file writes into
// per-source queues, a negedge monitor pops and compares every write the DUT presents.
module tb_reg_wb_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        pipe_wr_en;
   logic [4:0]  pipe_wr_addr;
   logic [31:0] pipe_wr_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        hazard_stall;
   logic        wb_bubble_req;
   logic        rf_regwrite;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic [31:0] pending;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t pipe_q[$];
   wr_t lu_q[$];
   int  vectors     = 0;
   int  miscompares = 0;

   always #5 clock = ~clock;

   reg_wb_arbiter #(
      .DEPTH      (4),
      .STARVE_MAX (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .pipe_wr_en    (pipe_wr_en),
      .pipe_wr_addr  (pipe_wr_addr),
      .pipe_wr_data  (pipe_wr_data),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_addr       (lu_addr),
      .lu_data       (lu_data),
      .issue_en      (issue_en),
      .issue_addr    (issue_addr),
      .chk_addr1     (chk_addr1),
      .chk_addr2     (chk_addr2),
      .hazard_stall  (hazard_stall),
      .wb_bubble_req (wb_bubble_req),
      .rf_regwrite   (rf_regwrite),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .pending       (pending)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic pipe_drive(input logic en, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      pipe_wr_en   = en;
      pipe_wr_addr = a;
      pipe_wr_data = d;
      if (en) begin
         e.addr = a;
         e.data = d;
         pipe_q.push_back(e);
      end
   endtask

   task automatic lu_expect(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      lu_q.push_back(e);
   endtask

   // Hold a result until accepted (bounded), then drop lu_valid one cycle later.
   task automatic lu_send(input logic [4:0] a, input logic [31:0] d);
      int n;
      lu_valid = 1'b1;
      lu_addr  = a;
      lu_data  = d;
      n = 0;
      while (!lu_ready && n < 20) begin
         tick();
         n++;
      end
      if (!lu_ready) begin
         check("lu_handshake_timeout", 32'(lu_ready), 32'd1);
      end else if (a != 5'd0) begin
         lu_expect(a, d);
      end
      tick();
      lu_valid = 1'b0;
   endtask

   // Monitor: every write the DUT presents must match the next expected write of its source.
   always @(negedge clock) begin
      wr_t e;
      if (rf_regwrite) begin
         if (pipe_wr_en) begin
            if (pipe_q.size() == 0) begin
               check("unexpected_pipe_write", 32'(rf_write_reg), 32'hFFFF_FFFF);
            end else begin
               e = pipe_q.pop_front();
               check("pipe_wr_reg", 32'(rf_write_reg), 32'(e.addr));
               check("pipe_wr_data", rf_write_data, e.data);
            end
         end else begin
            if (lu_q.size() == 0) begin
               check("unexpected_lu_write", 32'(rf_write_reg), 32'hFFFF_FFFF);
            end else begin
               e = lu_q.pop_front();
               check("lu_wr_reg", 32'(rf_write_reg), 32'(e.addr));
               check("lu_wr_data", rf_write_data, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset        = 1'b0;
      pipe_wr_en   = 1'b0;
      pipe_wr_addr = 5'd0;
      pipe_wr_data = 32'd0;
      lu_valid     = 1'b0;
      lu_addr      = 5'd0;
      lu_data      = 32'd0;
      issue_en     = 1'b0;
      issue_addr   = 5'd0;
      chk_addr1    = 5'd0;
      chk_addr2    = 5'd0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_regwrite", 32'(rf_regwrite), 32'd0);
      check("rst_write_reg", 32'(rf_write_reg), 32'd0);
      check("rst_write_data", rf_write_data, 32'd0);
      check("rst_lu_ready", 32'(lu_ready), 32'd1);
      check("rst_pending", pending, 32'd0);
      check("rst_bubble", 32'(wb_bubble_req), 32'd0);
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("idle_regwrite", 32'(rf_regwrite), 32'd0);
      check("idle_lu_ready", 32'(lu_ready), 32'd1);

      // Pipeline-only writeback
      tick();
      pipe_drive(1'b1, 5'd5, 32'h0000_1234);
      @(negedge clock);
      check("pipe_regwrite", 32'(rf_regwrite), 32'd1);
      tick();
      pipe_drive(1'b0, 5'd0, 32'd0);

      // Issue then complete on x7
      issue_en   = 1'b1;
      issue_addr = 5'd7;
      tick();
      issue_en  = 1'b0;
      chk_addr1 = 5'd7;
      @(negedge clock);
      check("issue7_pending", pending, 32'h0000_0080);
      check("issue7_hazard", 32'(hazard_stall), 32'd1);
      tick();
      lu_send(5'd7, 32'h0000_CAFE);
      tick();
      @(negedge clock);
      check("commit7_pending", pending, 32'd0);
      check("commit7_hazard", 32'(hazard_stall), 32'd0);
      chk_addr1 = 5'd0;

      // Fill under contention, starvation, then drain in push order
      for (int k = 0; k < 17; k++) begin
         tick();
         pipe_drive(k < 12, 5'd20, 32'h0000_1000 + 32'(k));
         if (k < 4) begin
            lu_valid = 1'b1;
            lu_addr  = 5'(10 + k);
            lu_data  = 32'h0000_A000 + 32'(k);
            lu_expect(lu_addr, lu_data);
         end else begin
            lu_valid = 1'b0;
         end
         @(negedge clock);
         if (k < 4)   check("fill_lu_ready", 32'(lu_ready), 32'd1);
         if (k == 4)  check("full_lu_ready", 32'(lu_ready), 32'd0);
         if (k == 4)  check("early_bubble", 32'(wb_bubble_req), 32'd0);
         if (k == 10) check("starve_bubble", 32'(wb_bubble_req), 32'd1);
         if (k == 11) check("sat_bubble", 32'(wb_bubble_req), 32'd1);
         if (k == 12) check("pop_no_bypass_ready", 32'(lu_ready), 32'd0);
         if (k == 14) check("bubble_cleared", 32'(wb_bubble_req), 32'd0);
         if (k == 16) check("drained_lu_ready", 32'(lu_ready), 32'd1);
      end
      check("drain_lu_q_empty", 32'(lu_q.size()), 32'd0);

      // Simultaneous set and clear on x3: set wins
      tick();
      issue_en   = 1'b1;
      issue_addr = 5'd3;
      tick();
      issue_en = 1'b0;
      pipe_drive(1'b1, 5'd21, 32'h0000_5555);
      lu_valid = 1'b1;
      lu_addr  = 5'd3;
      lu_data  = 32'h0000_3333;
      lu_expect(5'd3, 32'h0000_3333);
      tick();
      pipe_drive(1'b0, 5'd0, 32'd0);
      lu_valid   = 1'b0;
      issue_en   = 1'b1;
      issue_addr = 5'd3;
      @(negedge clock);
      check("setclr_commit_write", 32'(rf_regwrite), 32'd1);
      tick();
      issue_en = 1'b0;
      @(negedge clock);
      check("setclr_pending", pending, 32'h0000_0008);
      check("chk_x0_no_stall", 32'(hazard_stall), 32'd0);
      tick();
      chk_addr2 = 5'd3;
      @(negedge clock);
      check("chk2_x3_stall", 32'(hazard_stall), 32'd1);

      // x0: lu_addr=0 accepted but never written; issue_addr=0 sets nothing
      tick();
      chk_addr2  = 5'd0;
      issue_en   = 1'b1;
      issue_addr = 5'd0;
      lu_valid   = 1'b1;
      lu_addr    = 5'd0;
      lu_data    = 32'hDEAD_BEEF;
      @(negedge clock);
      check("x0_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      issue_en = 1'b0;
      lu_valid = 1'b0;
      tick();
      @(negedge clock);
      check("x0_pending", pending, 32'h0000_0008);

      // Async reset with three queued entries
      tick();
      pipe_drive(1'b1, 5'd22, 32'h0000_7000);
      lu_valid   = 1'b1;
      lu_addr    = 5'd14;
      lu_data    = 32'h0000_B000;
      lu_expect(5'd14, 32'h0000_B000);
      issue_en   = 1'b1;
      issue_addr = 5'd9;
      tick();
      issue_en = 1'b0;
      pipe_drive(1'b1, 5'd22, 32'h0000_7001);
      lu_addr = 5'd15;
      lu_data = 32'h0000_B001;
      lu_expect(5'd15, 32'h0000_B001);
      tick();
      pipe_drive(1'b1, 5'd22, 32'h0000_7002);
      lu_addr = 5'd16;
      lu_data = 32'h0000_B002;
      lu_expect(5'd16, 32'h0000_B002);
      @(negedge clock);
      check("prerst_pending", pending, 32'h0000_0208);
      tick();
      pipe_drive(1'b0, 5'd0, 32'd0);
      lu_valid = 1'b0;
      reset    = 1'b0;
      lu_q.delete();
      #1;
      check("midrst_pending", pending, 32'd0);
      check("midrst_lu_ready", 32'(lu_ready), 32'd1);
      check("midrst_regwrite", 32'(rf_regwrite), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (4) tick();
      @(negedge clock);
      check("postrst_pending", pending, 32'd0);
      check("postrst_regwrite", 32'(rf_regwrite), 32'd0);
      check("final_pipe_q_empty", 32'(pipe_q.size()), 32'd0);
      check("final_lu_q_empty", 32'(lu_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
